// File: rtl/bomb_scheduler.sv
// Bomb slot manager: per-slot fuse/flame timers, blast and clear walks, and the
// single tile-map write port. Every output is registered.
module bomb_scheduler #(
    parameter int         NUM_BOMBS    = 4,
    parameter int         FUSE_FRAMES  = 120,
    parameter int         FLAME_FRAMES = 30,
    parameter int         RANGE        = 2,
    parameter logic [3:0] T_EMPTY      = 4'd0,
    parameter logic [3:0] T_WALL       = 4'd1,
    parameter logic [3:0] T_BRICK      = 4'd2,
    parameter logic [3:0] T_BOMB       = 4'd3,
    parameter logic [3:0] T_FLAME      = 4'd4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       place_req,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    output logic       place_ack,
    output logic       place_nack,
    input  logic [3:0] map_array [0:191],
    output logic [3:0] changeX,
    output logic [3:0] changeY,
    output logic [3:0] change_to,
    output logic       change_enable,
    output logic       busy,
    output logic [2:0] active_count,
    output logic       explode_pulse
);
    localparam int   SW       = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1;
    localparam logic PH_FUSE  = 1'b0;
    localparam logic PH_FLAME = 1'b1;

    typedef enum logic [2:0] {S_IDLE, S_CENTER, S_WALK, S_CLR_CENTER, S_CLR_WALK} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t          state_reg, state_next;
    dir_t            dir_reg, dir_next;
    logic [4:0]      dist_reg, dist_next;
    logic [SW-1:0]   cur_reg, cur_next;

    logic            active_reg  [NUM_BOMBS];
    logic            active_next [NUM_BOMBS];
    logic [3:0]      x_reg       [NUM_BOMBS];
    logic [3:0]      x_next      [NUM_BOMBS];
    logic [3:0]      y_reg       [NUM_BOMBS];
    logic [3:0]      y_next      [NUM_BOMBS];
    logic [7:0]      timer_reg   [NUM_BOMBS];
    logic [7:0]      timer_next  [NUM_BOMBS];
    logic            phase_reg   [NUM_BOMBS];
    logic            phase_next  [NUM_BOMBS];
    logic            pending_reg [NUM_BOMBS];
    logic            pending_next[NUM_BOMBS];

    logic            ack_next, nack_next, explode_next, we_next, busy_next;
    logic [3:0]      cx_next, cy_next, cto_next;
    logic [2:0]      count_next;
    logic            end_dir;

    logic            pend_found, free_found;
    logic [SW-1:0]   pend_idx, free_idx;
    logic [3:0]      cur_x, cur_y;
    logic [5:0]      px, py;
    logic            probe_in;
    logic [3:0]      probe_tile, place_tile;

    assign cur_x = x_reg[cur_reg];
    assign cur_y = y_reg[cur_reg];

    // Probe coordinate kept as 6-bit two's complement so both edges of the map are visible.
    always_comb begin
        px = {2'b00, cur_x};
        py = {2'b00, cur_y};
        case (dir_reg)
            D_UP:    py = {2'b00, cur_y} - {1'b0, dist_reg};
            D_DOWN:  py = {2'b00, cur_y} + {1'b0, dist_reg};
            D_LEFT:  px = {2'b00, cur_x} - {1'b0, dist_reg};
            default: px = {2'b00, cur_x} + {1'b0, dist_reg};
        endcase
    end

    assign probe_in   = !px[5] && !px[4] && !py[5] && (py[4:0] <= 5'd11);
    assign probe_tile = probe_in ? map_array[{py[3:0], px[3:0]}] : T_WALL;
    assign place_tile = (place_y <= 4'd11) ? map_array[{place_y, place_x}] : T_WALL;

    always_comb begin
        pend_found = 1'b0;
        pend_idx   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
            if (active_reg[i] && pending_reg[i]) begin
                pend_found = 1'b1;
                pend_idx   = SW'(i);
            end
            if (!active_reg[i]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        dir_next     = dir_reg;
        dist_next    = dist_reg;
        cur_next     = cur_reg;
        ack_next     = 1'b0;
        nack_next    = 1'b0;
        explode_next = 1'b0;
        we_next      = 1'b0;
        cx_next      = 4'd0;
        cy_next      = 4'd0;
        cto_next     = 4'd0;
        end_dir      = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            active_next[i]  = active_reg[i];
            x_next[i]       = x_reg[i];
            y_next[i]       = y_reg[i];
            timer_next[i]   = timer_reg[i];
            phase_next[i]   = phase_reg[i];
            pending_next[i] = pending_reg[i];
            if (active_reg[i] && frame_tick && timer_reg[i] != 8'd0) begin
                timer_next[i] = timer_reg[i] - 8'd1;
                if (timer_reg[i] == 8'd1)
                    pending_next[i] = 1'b1;
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (pend_found) begin
                    cur_next = pend_idx;
                    if (phase_reg[pend_idx] == PH_FUSE) begin
                        state_next   = S_CENTER;
                        explode_next = 1'b1;
                    end else begin
                        state_next = S_CLR_CENTER;
                    end
                end else if (place_req && !place_ack && !place_nack) begin
                    // The request is still high during our own ack/nack cycle; ignore it there.
                    if (free_found && place_y <= 4'd11 && place_tile == T_EMPTY) begin
                        ack_next               = 1'b1;
                        we_next                = 1'b1;
                        cx_next                = place_x;
                        cy_next                = place_y;
                        cto_next               = T_BOMB;
                        active_next[free_idx]  = 1'b1;
                        x_next[free_idx]       = place_x;
                        y_next[free_idx]       = place_y;
                        phase_next[free_idx]   = PH_FUSE;
                        timer_next[free_idx]   = 8'(FUSE_FRAMES);
                        pending_next[free_idx] = 1'b0;
                    end else begin
                        nack_next = 1'b1;
                    end
                end
            end
            S_CENTER, S_CLR_CENTER: begin
                we_next    = 1'b1;
                cx_next    = cur_x;
                cy_next    = cur_y;
                cto_next   = (state_reg == S_CENTER) ? T_FLAME : T_EMPTY;
                dir_next   = D_UP;
                dist_next  = 5'd1;
                state_next = (state_reg == S_CENTER) ? S_WALK : S_CLR_WALK;
            end
            S_WALK: begin
                if (!probe_in || probe_tile == T_WALL) begin
                    end_dir = 1'b1;
                end else begin
                    we_next  = 1'b1;
                    cx_next  = px[3:0];
                    cy_next  = py[3:0];
                    cto_next = T_FLAME;
                    if (probe_tile == T_BRICK) begin
                        end_dir = 1'b1;
                    end else if (probe_tile == T_BOMB) begin
                        end_dir = 1'b1;
                        for (int j = 0; j < NUM_BOMBS; j++) begin
                            if (active_reg[j] && phase_reg[j] == PH_FUSE && SW'(j) != cur_reg &&
                                x_reg[j] == px[3:0] && y_reg[j] == py[3:0]) begin
                                timer_next[j]   = 8'd0;
                                pending_next[j] = 1'b1;
                            end
                        end
                    end else if (dist_reg == 5'(RANGE)) begin
                        end_dir = 1'b1;
                    end
                end
                if (end_dir && dir_reg == D_RIGHT) begin
                    state_next            = S_IDLE;
                    phase_next[cur_reg]   = PH_FLAME;
                    timer_next[cur_reg]   = 8'(FLAME_FRAMES);
                    pending_next[cur_reg] = 1'b0;
                end
            end
            S_CLR_WALK: begin
                if (probe_in && probe_tile == T_FLAME && dist_reg <= 5'(RANGE)) begin
                    we_next  = 1'b1;
                    cx_next  = px[3:0];
                    cy_next  = py[3:0];
                    cto_next = T_EMPTY;
                end else begin
                    end_dir = 1'b1;
                end
                if (end_dir && dir_reg == D_RIGHT) begin
                    state_next            = S_IDLE;
                    active_next[cur_reg]  = 1'b0;
                    pending_next[cur_reg] = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (state_reg == S_WALK || state_reg == S_CLR_WALK) begin
            if (end_dir) begin
                dir_next  = dir_t'(dir_reg + 2'd1);
                dist_next = 5'd1;
            end else begin
                dist_next = dist_reg + 5'd1;
            end
        end

        busy_next  = (state_next != S_IDLE);
        count_next = 3'd0;
        for (int i = 0; i < NUM_BOMBS; i++)
            count_next = count_next + 3'(active_next[i]);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= S_IDLE;
            dir_reg       <= D_UP;
            dist_reg      <= 5'd1;
            cur_reg       <= '0;
            place_ack     <= 1'b0;
            place_nack    <= 1'b0;
            explode_pulse <= 1'b0;
            change_enable <= 1'b0;
            changeX       <= 4'd0;
            changeY       <= 4'd0;
            change_to     <= 4'd0;
            busy          <= 1'b0;
            active_count  <= 3'd0;
        end else begin
            state_reg     <= state_next;
            dir_reg       <= dir_next;
            dist_reg      <= dist_next;
            cur_reg       <= cur_next;
            place_ack     <= ack_next;
            place_nack    <= nack_next;
            explode_pulse <= explode_next;
            change_enable <= we_next;
            changeX       <= cx_next;
            changeY       <= cy_next;
            change_to     <= cto_next;
            busy          <= busy_next;
            active_count  <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BOMBS; gi++) begin : g_slot
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    active_reg[gi]  <= 1'b0;
                    x_reg[gi]       <= 4'd0;
                    y_reg[gi]       <= 4'd0;
                    timer_reg[gi]   <= 8'd0;
                    phase_reg[gi]   <= PH_FUSE;
                    pending_reg[gi] <= 1'b0;
                end else begin
                    active_reg[gi]  <= active_next[gi];
                    x_reg[gi]       <= x_next[gi];
                    y_reg[gi]       <= y_next[gi];
                    timer_reg[gi]   <= timer_next[gi];
                    phase_reg[gi]   <= phase_next[gi];
                    pending_reg[gi] <= pending_next[gi];
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_bomb_scheduler.sv
// Scoreboard bench for bomb_scheduler: stimulus queues expected ack/nack/explode/write
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_bomb_scheduler;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       place_req;
    logic [3:0] place_x, place_y;
    logic       place_ack, place_nack;
    logic [3:0] map_array [0:191];
    logic [3:0] changeX, changeY, change_to;
    logic       change_enable, busy, explode_pulse;
    logic [2:0] active_count;

    bomb_scheduler dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .place_req(place_req), .place_x(place_x), .place_y(place_y),
        .place_ack(place_ack), .place_nack(place_nack), .map_array(map_array),
        .changeX(changeX), .changeY(changeY), .change_to(change_to),
        .change_enable(change_enable), .busy(busy), .active_count(active_count),
        .explode_pulse(explode_pulse)
    );

    always #5 Clk = ~Clk;

    localparam logic [1:0] EV_ACK = 2'd0, EV_NACK = 2'd1, EV_EXP = 2'd2, EV_WR = 2'd3;
    typedef struct packed { logic [1:0] kind; logic [3:0] x; logic [3:0] y; logic [3:0] v; } ev_t;
    typedef struct packed { logic busy; logic [2:0] cnt; logic quiet; } st_t;

    ev_t exp_q [$];
    st_t st_q  [$];
    int  tests = 0;
    int  fails = 0;
    logic status_req, done, drained;
    logic poke_en, map_clr;
    logic [7:0] poke_idx;
    logic [3:0] poke_val;

    // Map model: the DUT's writes land here and become visible the following cycle.
    always @(posedge Clk) begin
        if (map_clr) begin
            for (int i = 0; i < 192; i++) map_array[i] <= 4'd0;
        end else if (poke_en) begin
            map_array[poke_idx] <= poke_val;
        end else if (change_enable) begin
            map_array[{changeY, changeX}] <= change_to;
        end
    end

    function automatic string ev_str(input ev_t e);
        case (e.kind)
            EV_ACK:  return "ack";
            EV_NACK: return "nack";
            EV_EXP:  return "explode";
            default: return $sformatf("write (%0d,%0d)<-%0d", e.x, e.y, e.v);
        endcase
    endfunction

    task automatic check_ev(input logic [1:0] k, input logic [3:0] x, input logic [3:0] y, input logic [3:0] v);
        ev_t got, want;
        got.kind = k; got.x = x; got.y = y; got.v = v;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: got %s, expected no event", ev_str(got));
        end else begin
            want = exp_q.pop_front();
            if (want != got) begin
                fails++;
                $display("FAIL event: got %s, expected %s", ev_str(got), ev_str(want));
            end else begin
                $display("[TB] t=%0t %s", $time, ev_str(got));
            end
        end
    endtask

    initial drained = 1'b0;

    always @(negedge Clk) begin
        st_t s;
        if (place_ack)     check_ev(EV_ACK, 4'd0, 4'd0, 4'd0);
        if (place_nack)    check_ev(EV_NACK, 4'd0, 4'd0, 4'd0);
        if (explode_pulse) check_ev(EV_EXP, 4'd0, 4'd0, 4'd0);
        if (change_enable) check_ev(EV_WR, changeX, changeY, change_to);
        if (status_req && st_q.size() > 0) begin
            s = st_q.pop_front();
            tests++;
            if (busy != s.busy || active_count != s.cnt) begin
                fails++;
                $display("FAIL status: busy=%0d active_count=%0d, expected busy=%0d active_count=%0d",
                         busy, active_count, s.busy, s.cnt);
            end else if (s.quiet && (place_ack || place_nack || explode_pulse || change_enable ||
                                     changeX != 4'd0 || changeY != 4'd0 || change_to != 4'd0)) begin
                fails++;
                $display("FAIL quiet: ack=%0d nack=%0d exp=%0d we=%0d x=%0d y=%0d to=%0d, expected all 0",
                         place_ack, place_nack, explode_pulse, change_enable, changeX, changeY, change_to);
            end else begin
                $display("[TB] t=%0t status busy=%0d active_count=%0d", $time, busy, active_count);
            end
        end
        if (done && !drained) begin
            while (exp_q.size() > 0) begin
                tests++;
                fails++;
                $display("FAIL missing: expected %s, never seen", ev_str(exp_q.pop_front()));
            end
            drained = 1'b1;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input int x, input int y, input int v);
        ev_t e;
        e.kind = k; e.x = 4'(x); e.y = 4'(y); e.v = 4'(v);
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input int x, input int y, input int v);
        push(EV_WR, x, y, v);
    endtask

    task automatic place(input int x, input int y);
        place_x   = 4'(x);
        place_y   = 4'(y);
        place_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (place_ack || place_nack) break;
        end
        place_req = 1'b0;
        step();
    endtask

    task automatic check_status(input logic b, input int cnt, input logic quiet);
        st_t s;
        s.busy = b; s.cnt = 3'(cnt); s.quiet = quiet;
        st_q.push_back(s);
        status_req = 1'b1;
        step();
        status_req = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(); step(); step();
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic poke(input int x, input int y, input int v);
        poke_idx = 8'(y * 16 + x);
        poke_val = 4'(v);
        poke_en  = 1'b1;
        step();
        poke_en  = 1'b0;
    endtask

    task automatic push_plus(input int v, input int x, input int y);
        // Full open-map blast/clear pattern with RANGE 2, centre first.
        push_wr(x, y, v);
        push_wr(x, y - 1, v); push_wr(x, y - 2, v);
        push_wr(x, y + 1, v); push_wr(x, y + 2, v);
        push_wr(x - 1, y, v); push_wr(x - 2, y, v);
        push_wr(x + 1, y, v); push_wr(x + 2, y, v);
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; place_req = 1'b0; place_x = 4'd0; place_y = 4'd0;
        poke_en = 1'b0; poke_idx = 8'd0; poke_val = 4'd0; map_clr = 1'b1;
        status_req = 1'b0; done = 1'b0;
        repeat (3) step();
        map_clr = 1'b0;
        check_status(1'b0, 0, 1'b1);
        Reset = 1'b0;
        step();
        check_status(1'b0, 0, 1'b1);

        // Placement accept, then duplicate rejected by the bomb tile.
        push(EV_ACK, 0, 0, 0); push_wr(3, 3, 3);
        place(3, 3);
        check_status(1'b0, 1, 1'b0);
        push(EV_NACK, 0, 0, 0);
        place(3, 3);
        check_status(1'b0, 1, 1'b0);

        // Open-map blast and clear.
        push(EV_EXP, 0, 0, 0);
        push_plus(4, 3, 3);
        ticks(120);
        repeat (30) step();
        check_status(1'b0, 1, 1'b0);
        push_plus(0, 3, 3);
        ticks(30);
        repeat (30) step();
        check_status(1'b0, 0, 1'b0);

        // Wall above stops UP, brick below takes flame and stops DOWN.
        poke(3, 2, 1);
        poke(3, 4, 2);
        push(EV_ACK, 0, 0, 0); push_wr(3, 3, 3);
        place(3, 3);
        push(EV_EXP, 0, 0, 0);
        push_wr(3, 3, 4); push_wr(3, 4, 4);
        push_wr(2, 3, 4); push_wr(1, 3, 4); push_wr(4, 3, 4); push_wr(5, 3, 4);
        ticks(120);
        repeat (30) step();
        push_wr(3, 3, 0); push_wr(3, 4, 0);
        push_wr(2, 3, 0); push_wr(1, 3, 0); push_wr(4, 3, 0); push_wr(5, 3, 0);
        ticks(30);
        repeat (30) step();
        check_status(1'b0, 0, 1'b0);
        poke(3, 2, 0);

        // Corner bomb: UP and LEFT fall off the map.
        push(EV_ACK, 0, 0, 0); push_wr(0, 0, 3);
        place(0, 0);
        push(EV_EXP, 0, 0, 0);
        push_wr(0, 0, 4); push_wr(0, 1, 4); push_wr(0, 2, 4); push_wr(1, 0, 4); push_wr(2, 0, 4);
        ticks(120);
        repeat (30) step();
        push_wr(0, 0, 0); push_wr(0, 1, 0); push_wr(0, 2, 0); push_wr(1, 0, 0); push_wr(2, 0, 0);
        ticks(30);
        repeat (30) step();
        check_status(1'b0, 0, 1'b0);

        // Chain reaction: first blast reaches the second bomb.
        push(EV_ACK, 0, 0, 0); push_wr(3, 3, 3);
        place(3, 3);
        ticks(60);
        push(EV_ACK, 0, 0, 0); push_wr(5, 3, 3);
        place(5, 3);
        check_status(1'b0, 2, 1'b0);
        push(EV_EXP, 0, 0, 0);
        push_wr(3, 3, 4); push_wr(3, 2, 4); push_wr(3, 1, 4); push_wr(3, 4, 4); push_wr(3, 5, 4);
        push_wr(2, 3, 4); push_wr(1, 3, 4); push_wr(4, 3, 4); push_wr(5, 3, 4);
        push(EV_EXP, 0, 0, 0);
        push_wr(5, 3, 4); push_wr(5, 2, 4); push_wr(5, 1, 4); push_wr(5, 4, 4); push_wr(5, 5, 4);
        push_wr(4, 3, 4); push_wr(3, 3, 4); push_wr(6, 3, 4); push_wr(7, 3, 4);
        ticks(60);
        repeat (60) step();
        check_status(1'b0, 2, 1'b0);
        push_wr(3, 3, 0); push_wr(3, 2, 0); push_wr(3, 1, 0); push_wr(3, 4, 0); push_wr(3, 5, 0);
        push_wr(2, 3, 0); push_wr(1, 3, 0); push_wr(4, 3, 0); push_wr(5, 3, 0);
        push_wr(5, 3, 0); push_wr(5, 2, 0); push_wr(5, 1, 0); push_wr(5, 4, 0); push_wr(5, 5, 0);
        push_wr(6, 3, 0); push_wr(7, 3, 0);
        ticks(30);
        repeat (60) step();
        check_status(1'b0, 0, 1'b0);

        // Fill every slot, one more is refused; then reset in the middle of a walk.
        push(EV_ACK, 0, 0, 0); push_wr(10, 6, 3);  place(10, 6);
        push(EV_ACK, 0, 0, 0); push_wr(12, 6, 3);  place(12, 6);
        push(EV_ACK, 0, 0, 0); push_wr(10, 9, 3);  place(10, 9);
        push(EV_ACK, 0, 0, 0); push_wr(13, 9, 3);  place(13, 9);
        check_status(1'b0, 4, 1'b0);
        push(EV_NACK, 0, 0, 0);
        place(7, 7);
        check_status(1'b0, 4, 1'b0);
        push(EV_EXP, 0, 0, 0); push_wr(10, 6, 4); push_wr(10, 5, 4);
        ticks(120);
        for (int i = 0; i < 10 && !explode_pulse; i++) step();
        step();
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_status(1'b0, 0, 1'b1);
        repeat (10) step();
        check_status(1'b0, 0, 1'b1);

        done = 1'b1;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bomb_scheduler.md
Name: bomb_scheduler

Overview:
Owns the bomb lifecycle and is the sole writer of the shared tile-map write port (changeX/changeY/change_to/change_enable) in bomberman.
- Accepts bomb placements from the player logic and runs one fuse timer per bomb slot, counted in frames.
- On expiry, walks the blast pattern into the map one tile per cycle.
- Later walks it back to empty; triggers chain reactions when a blast reaches another bomb.

Parameters:
NUM_BOMBS, 4, bomb slots (1..7)
FUSE_FRAMES, 120, frames from placement to explosion (1..255)
FLAME_FRAMES, 30, frames flames persist before clearing (1..255)
RANGE, 2, blast reach in tiles per direction (1..15)
T_EMPTY/T_WALL/T_BRICK/T_BOMB/T_FLAME, 0/1/2/3/4, tile codes

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
frame_tick  in  1  one-Clk pulse per video frame
place_req  in  1  placement request; held until ack or nack
place_x  in  4  column 0..15
place_y  in  4  row 0..11
place_ack  out  1  one-cycle pulse: placement accepted
place_nack  out  1  one-cycle pulse: placement rejected
map_array  in  [0:191][4]  current map; tile(x,y)=map_array[y*16+x]
changeX  out  4  write column
changeY  out  4  write row
change_to  out  4  tile code to write
change_enable  out  1  one-cycle write strobe
busy  out  1  high in any state other than S_IDLE
active_count  out  3  occupied slots
explode_pulse  out  1  one-cycle pulse when an explosion starts

Behaviour:
- Reset: all outputs 0, all slots free, state S_IDLE. Map contents are not restored; reset mid-walk abandons the walk.
- All outputs are registered. A decision made in cycle n appears in cycle n+1.
- Map write rules:
  - At most one write per cycle.
  - change_enable is high for exactly one cycle per write.
  - The map reflects the write from the following cycle.
- Slot fields: active, x, y, timer[7:0], phase (FUSE/FLAME), pending.
- Timers:
  - On frame_tick, every active slot with timer>0 decrements, independent of state.
  - When timer reaches 0, pending=1.
  - A chain force (timer:=0, pending:=1) in the same cycle as frame_tick wins.
- S_IDLE priority, evaluated each cycle:
  - (1) Lowest-index pending slot: FUSE phase goes to S_CENTER with explode_pulse; FLAME phase goes to S_CLR_CENTER.
  - (2) Else, if place_req: accept only when a free slot exists and tile(place_x,place_y)==T_EMPTY and place_y<=11.
    - Accept: next cycle place_ack=1, write T_BOMB at (place_x,place_y), lowest free slot gets active, FUSE, timer=FUSE_FRAMES.
    - Otherwise: next cycle place_nack=1, no write.
  - A req arriving while busy gets no response until S_IDLE.
  - A pending slot starves placement.
- S_CENTER:
  - Write T_FLAME at slot centre.
  - Set dir=UP, dist=1, go to S_WALK.
- S_WALK: one probe per cycle at centre+dist*dir. Direction order: UP(y-1), DOWN, LEFT(x-1), RIGHT.
  - Out of bounds (x<0, x>15, y<0, y>11) or T_WALL: no write; end direction.
  - T_BRICK: write T_FLAME; end direction.
  - T_BOMB: write T_FLAME; chain-force the active FUSE slot at that coordinate; end direction.
  - Otherwise: write T_FLAME; if dist==RANGE end direction, else dist+1.
  - End direction: next dir with dist=1. After RIGHT ends, the slot takes phase FLAME, timer=FLAME_FRAMES, pending=0, and the FSM returns to S_IDLE.
  - The slot's own centre is never probed.
- S_CLR_CENTER: write T_EMPTY at centre; go to S_CLR_WALK.
- S_CLR_WALK: same direction order and probe timing.
  - tile==T_FLAME and dist<=RANGE: write T_EMPTY, continue.
  - Anything else ends the direction with no write.
  - After RIGHT: slot freed, return to S_IDLE.
- Probe cycles without a write still take one cycle, so walk length is deterministic.
- active_count equals the number of active slots, updated the cycle after change.

Test Plan:
- Empty map, place (3,3) -> next cycle place_ack=1, change_enable=1, (3,3)<-3, active_count=1; a second req at (3,3) -> place_nack.
- After 120 frame_ticks on an open map, RANGE=2 -> explode_pulse; writes of 4 at (3,3),(3,2),(3,1),(3,4),(3,5),(2,3),(1,3),(4,3),(5,3). After 30 more ticks, the same 9 tiles are written to 0; active_count=0.
- Wall at (3,2), brick at (3,4) -> no UP writes, (3,4)<-4, (3,5) untouched; clear restores (3,4)=0.
- Bomb at (0,0) -> UP and LEFT probes are out of bounds with no writes, 5 writes total.
- Bombs at (3,3) and (5,3), the second placed 60 frames later -> first blast writes (5,3)<-4; second explodes on the next S_IDLE cycle with a second explode_pulse.
- NUM_BOMBS placements then one more -> nack; Reset asserted mid-S_WALK -> next cycle all outputs 0, busy=0, active_count=0.
